// File: rtl/nes_pkg.sv
// rtl/nes_pkg.sv - opcodes, loader states, status bit positions and register map
package nes_pkg;

  typedef enum logic [7:0] {
    OP_RESET_CPU   = 8'd0,
    OP_START_CPU   = 8'd1,
    OP_START_WRITE = 8'd2,
    OP_WRITE       = 8'd3,
    OP_STOP_WRITE  = 8'd4
  } opcode_e;

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_LOAD  = 2'd1,
    S_RUN   = 2'd2
  } state_e;

  // Status word layout
  localparam int STAT_OVF_BIT   = 15;
  localparam int STAT_ERR_BIT   = 14;
  localparam int STAT_STATE_LSB = 12;
  localparam int STAT_COUNT_LSB = 0;

  // Host read register map
  localparam int REG_STATUS   = 0;
  localparam int REG_PROG_END = 1;

endpackage

// File: rtl/nes_cmd_fifo.sv
// rtl/nes_cmd_fifo.sv - synchronous command FIFO with full/empty/count
module nes_cmd_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  // Fullness is judged on the current count, so a push into a full FIFO is refused even if a pop happens this cycle
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];

  // Storage array; no reset needed since count gates every read
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointer and occupancy tracking
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/nes_host_loader.sv
// rtl/nes_host_loader.sv - host command queue driving program memory loads and CPU control
module nes_host_loader
  import nes_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_chipselect,
  input  logic              i_write,
  input  logic [15:0]       i_writedata,
  input  logic [ADDR_W-1:0] i_address,
  input  logic              i_read,
  output logic [15:0]       o_readdata,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_write,
  output logic [7:0]        o_mem_in,
  output logic              o_cpu_reset,
  output logic              o_cpu_ready
);

  localparam int ENTRY_W = 16 + ADDR_W;
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;

  logic [ENTRY_W-1:0] w_entry;
  logic               w_full;
  logic               w_empty;
  logic [CNT_W-1:0]   w_count;
  logic               w_push;
  logic               w_pop;
  logic               w_ovf_evt;
  logic               w_cmd_err_evt;
  logic               w_status_rd;
  logic [7:0]         w_op;
  logic [7:0]         w_data;
  logic [ADDR_W-1:0]  w_addr;
  logic [15:0]        w_status;

  state_e             r_state;
  logic [ADDR_W-1:0]  r_prog_end;
  logic               r_overflow;
  logic               r_cmd_error;

  // Host writes landing in a reset cycle are discarded silently
  assign w_push      = i_chipselect && i_write && !i_reset;
  assign w_ovf_evt   = w_push && w_full;
  assign w_pop       = !w_empty;
  assign w_status_rd = i_chipselect && i_read && (i_address == ADDR_W'(REG_STATUS));

  assign w_op   = w_entry[ENTRY_W-1 -: 8];
  assign w_data = w_entry[ADDR_W +: 8];
  assign w_addr = w_entry[ADDR_W-1:0];

  nes_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (w_push),
    .i_data  ({i_writedata, i_address}),
    .i_pop   (w_pop),
    .o_data  (w_entry),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Flag a known opcode popped in a state where it has no meaning; unknown opcodes are simply skipped
  always_comb begin
    w_cmd_err_evt = 1'b0;
    if (w_pop) begin
      case (w_op)
        OP_START_CPU, OP_START_WRITE: w_cmd_err_evt = (r_state != S_RESET);
        OP_WRITE, OP_STOP_WRITE:      w_cmd_err_evt = (r_state != S_LOAD);
        default:                      w_cmd_err_evt = 1'b0;
      endcase
    end
  end

  // Assemble the status word from the live flags, state and queue depth
  always_comb begin
    w_status                              = '0;
    w_status[STAT_OVF_BIT]                = r_overflow;
    w_status[STAT_ERR_BIT]                = r_cmd_error;
    w_status[STAT_STATE_LSB +: 2]         = r_state;
    w_status[STAT_COUNT_LSB +: 4]         = 4'(w_count);
  end

  // Command execution: one popped entry per cycle updates state and memory/CPU outputs
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_RESET;
      o_cpu_reset <= 1'b1;
      o_cpu_ready <= 1'b0;
      o_mem_write <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_in    <= '0;
      r_prog_end  <= '0;
    end else begin
      o_mem_write <= 1'b0;
      if (w_pop) begin
        case (w_op)
          OP_RESET_CPU: begin
            r_state     <= S_RESET;
            o_cpu_reset <= 1'b1;
            o_cpu_ready <= 1'b0;
            r_prog_end  <= '0;
          end
          OP_START_CPU: begin
            if (r_state == S_RESET) begin
              r_state     <= S_RUN;
              o_cpu_reset <= 1'b0;
              o_cpu_ready <= 1'b1;
            end
          end
          OP_START_WRITE: begin
            if (r_state == S_RESET) begin
              r_state     <= S_LOAD;
              o_mem_addr  <= w_addr;
              o_mem_in    <= w_data;
              o_mem_write <= 1'b1;
              r_prog_end  <= w_addr + 1'b1;
            end
          end
          OP_WRITE: begin
            if (r_state == S_LOAD) begin
              o_mem_addr  <= o_mem_addr + 1'b1;
              o_mem_in    <= w_data;
              o_mem_write <= 1'b1;
              r_prog_end  <= r_prog_end + 1'b1;
            end
          end
          OP_STOP_WRITE: begin
            if (r_state == S_LOAD) r_state <= S_RESET;
          end
          default: ;
        endcase
      end
    end
  end

  // Sticky error flags; a status read clears them unless a new event arrives in the same cycle
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_overflow  <= 1'b0;
      r_cmd_error <= 1'b0;
    end else begin
      r_overflow  <= w_ovf_evt     || (r_overflow  && !w_status_rd);
      r_cmd_error <= w_cmd_err_evt || (r_cmd_error && !w_status_rd);
    end
  end

  // Registered host read port
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_readdata <= '0;
    end else if (i_chipselect && i_read) begin
      if (i_address == ADDR_W'(REG_STATUS))        o_readdata <= w_status;
      else if (i_address == ADDR_W'(REG_PROG_END)) o_readdata <= 16'(r_prog_end);
      else                                         o_readdata <= '0;
    end
  end

endmodule

// File: doc/nes_host_loader.md
NES_HOST_LOADER -- requirements
Module: nes_host_loader

Interface
REQ-001 Parameter FIFO_DEPTH, default 8: command FIFO entries, power of two, at least 2.
REQ-002 Parameter ADDR_W, default 16: memory address width.
REQ-003 clk  in  1  single clock; all logic on posedge clk.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 chipselect  in  1  host slave select.
REQ-006 write  in  1  host write strobe; qualified by chipselect.
REQ-007 writedata  in  16  [15:8] opcode, [7:0] data byte.
REQ-008 address  in  ADDR_W  START_WRITE base address; on reads, the register select.
REQ-009 read  in  1  host read strobe; qualified by chipselect.
REQ-010 readdata  out  16  registered read data.
REQ-011 mem_addr  out  ADDR_W  program memory address.
REQ-012 mem_write  out  1  program memory write strobe.
REQ-013 mem_in  out  8  program memory write data.
REQ-014 cpu_reset  out  1  CPU reset request.
REQ-015 cpu_ready  out  1  CPU run enable.

Function
REQ-016 Opcodes: RESET_CPU=0, START_CPU=1, START_WRITE=2, WRITE=3, STOP_WRITE=4; other values are accepted into the FIFO and ignored when popped.
REQ-017 Push: chipselect&write with FIFO not full stores {opcode, data, address}.
REQ-018 Push when full: entry dropped, overflow flag set; fullness is judged before any same-cycle pop.
REQ-019 Simultaneous push and pop with FIFO not full: count unchanged, order preserved.
REQ-020 At most one entry popped per cycle whenever FIFO is non-empty; effect is registered, so an entry pushed into an empty FIFO in cycle N appears on outputs in cycle N+2.
REQ-021 States: S_RESET (0), S_LOAD (1), S_RUN (2).
REQ-022 RESET_CPU, any state -> S_RESET: cpu_reset=1, cpu_ready=0, mem_write=0, program_end=0.
REQ-023 START_WRITE in S_RESET -> S_LOAD: mem_addr=address, mem_in=data, mem_write=1, program_end=address+1.
REQ-024 WRITE in S_LOAD: mem_addr+1, mem_in=data, mem_write=1, program_end+1; both wrap 0xFFFF->0x0000 modulo 2^ADDR_W.
REQ-025 STOP_WRITE in S_LOAD -> S_RESET.
REQ-026 START_CPU in S_RESET -> S_RUN: cpu_reset=0, cpu_ready=1.
REQ-027 Any other opcode/state combination: no output change, state held, cmd_error flag set.
REQ-028 mem_write high for exactly the cycle following each accepted START_WRITE or WRITE pop; low otherwise.
REQ-029 Read, registered, valid one cycle after chipselect&read: address 0 = status {[15] overflow, [14] cmd_error, [13:12] state, [11:4] 0, [3:0] fifo count}; address 1 = program_end; other addresses = 0.
REQ-030 A status read clears overflow and cmd_error on the following cycle; a new error event in the same cycle wins (flag stays set).

Reset
REQ-031 On reset: state=S_RESET, cpu_reset=1, cpu_ready=0, mem_write=0, mem_addr=0, mem_in=0, program_end=0, FIFO empty, flags=0, readdata=0.
REQ-032 Reset mid-load discards all queued entries and aborts any pending memory write; host writes in the reset cycle are dropped without setting overflow.

Structure
REQ-033 Package nes_pkg holds the opcode enum, the state enum, status bit positions and register addresses.
REQ-034 One sub-module, nes_cmd_fifo: synchronous FIFO with push, pop, full, empty and count.

Verification
REQ-035 Reset, then read address 0 -> readdata=0x0000 (S_RESET, empty, no flags); cpu_reset=1.
REQ-036 START_WRITE addr 0x8000 data 0xA9, then WRITE 0x01, WRITE 0x00, STOP_WRITE -> mem_write pulses at 0x8000/0xA9, 0x8001/0x01, 0x8002/0x00; program_end=0x8003; final state S_RESET.
REQ-037 START_WRITE addr 0xFFFF data 0x11, then WRITE 0x22 -> second write lands at 0x0000; program_end=0x0001.
REQ-038 Ten back-to-back pushes while pops are stalled by a forced-full FIFO (depth 8) -> overflow=1; the first status read returns bit15=1, and a second read returns bit15=0.
REQ-039 WRITE issued in S_RESET, then START_CPU -> no mem_write; cmd_error set; state S_RUN, cpu_reset=0, cpu_ready=1.
REQ-040 Reset asserted mid-load with 3 entries queued -> no further mem_write pulses; count=0; state S_RESET.
